// File: rtl/vm_pkg.sv
// Vending-machine shared definitions: price width, default product prices,
// product index type and the write-port result encoding.
package vm_pkg;

  localparam int unsigned PRICE_W      = 8;
  localparam int unsigned NUM_PRODUCTS = 4;

  localparam logic [PRICE_W-1:0] PRICE_P0 = 8'd10;
  localparam logic [PRICE_W-1:0] PRICE_P1 = 8'd20;
  localparam logic [PRICE_W-1:0] PRICE_P2 = 8'd40;
  localparam logic [PRICE_W-1:0] PRICE_P3 = 8'd0;

  // Slot i lives at bits [i*PRICE_W +: PRICE_W]
  localparam logic [NUM_PRODUCTS*PRICE_W-1:0] DEFAULT_PRICES =
    {PRICE_P3, PRICE_P2, PRICE_P1, PRICE_P0};

  typedef logic [$clog2(NUM_PRODUCTS)-1:0] product_idx_t;

  // Outcome of a write strobe, reported one cycle later
  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ACK,
    WR_ERR
  } wr_result_e;

endpackage

// File: rtl/price_regfile.sv
// Price register file: one register per product slot, async reset to the
// default price, one synchronous write port, one combinational read port.
// Selectors with no matching slot read as zero and write nothing.
module price_regfile
  import vm_pkg::*;
#(
  parameter int unsigned NUM_PRODUCTS = 4,
  parameter int unsigned PRICE_W      = 8,
  parameter int unsigned SEL_W        = $clog2(NUM_PRODUCTS),
  parameter logic [NUM_PRODUCTS*PRICE_W-1:0] DEFAULT_PRICES = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [SEL_W-1:0]   wr_sel,
  input  logic [PRICE_W-1:0] wr_data,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic [PRICE_W-1:0] rd_data
);

  logic [PRICE_W-1:0] price_q [NUM_PRODUCTS];
  logic [PRICE_W-1:0] price_d [NUM_PRODUCTS];

  // Next-state: decode the write selector onto the matching slot
  always_comb begin
    for (int unsigned i = 0; i < NUM_PRODUCTS; i++) begin
      price_d[i] = price_q[i];
      if (wr_en && (wr_sel == SEL_W'(i))) begin
        price_d[i] = wr_data;
      end
    end
  end

  // Price registers, reverting to the default table on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PRODUCTS; i++) begin
        price_q[i] <= DEFAULT_PRICES[i*PRICE_W +: PRICE_W];
      end
    end else begin
      for (int unsigned i = 0; i < NUM_PRODUCTS; i++) begin
        price_q[i] <= price_d[i];
      end
    end
  end

  // Read mux; a selector matching no slot yields zero
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_PRODUCTS; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_data = price_q[i];
      end
    end
  end

endmodule

// File: rtl/product_price_table.sv
// Programmable product price table: registered price queries with
// availability flag, plus a lockable write port with ack/err pulses.
module product_price_table
  import vm_pkg::*;
#(
  parameter int unsigned NUM_PRODUCTS = 4,
  parameter int unsigned PRICE_W      = vm_pkg::PRICE_W,
  parameter int unsigned SEL_W        = $clog2(NUM_PRODUCTS),
  parameter logic [NUM_PRODUCTS*PRICE_W-1:0] DEFAULT_PRICES =
    vm_pkg::DEFAULT_PRICES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [SEL_W-1:0]   req_sel,
  output logic               rsp_valid,
  output logic [PRICE_W-1:0] rsp_cost,
  output logic               rsp_avail,
  input  logic               wr_en,
  input  logic [SEL_W-1:0]   wr_sel,
  input  logic [PRICE_W-1:0] wr_price,
  input  logic               lock,
  output logic               wr_ack,
  output logic               wr_err
);

  logic               req_in_range;
  logic               wr_in_range;
  logic               wr_accept;
  logic [PRICE_W-1:0] rd_data;

  logic               rsp_valid_q, rsp_valid_d;
  logic [PRICE_W-1:0] rsp_cost_q,  rsp_cost_d;
  logic               rsp_avail_q, rsp_avail_d;
  wr_result_e         wr_res_q,    wr_res_d;

  // Range checks only exist when the selector can exceed the slot count
  if (NUM_PRODUCTS == (1 << SEL_W)) begin : g_pow2
    // Every selector value names a real slot
    always_comb begin
      req_in_range = 1'b1;
      wr_in_range  = 1'b1;
    end
  end else begin : g_npow2
    // Compare selectors against the slot count
    always_comb begin
      req_in_range = (req_sel < SEL_W'(NUM_PRODUCTS));
      wr_in_range  = (wr_sel  < SEL_W'(NUM_PRODUCTS));
    end
  end

  // A write is accepted only when unlocked and aimed at a real slot
  always_comb begin
    wr_accept = wr_en && !lock && wr_in_range;
  end

  // The read port sees the pre-edge table, so a same-cycle write to the
  // queried slot is not visible in that query's response.
  price_regfile #(
    .NUM_PRODUCTS  (NUM_PRODUCTS),
    .PRICE_W       (PRICE_W),
    .SEL_W         (SEL_W),
    .DEFAULT_PRICES(DEFAULT_PRICES)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_accept),
    .wr_sel (wr_sel),
    .wr_data(wr_price),
    .rd_sel (req_sel),
    .rd_data(rd_data)
  );

  // Response and write-result next state; response fields hold when idle
  always_comb begin
    rsp_valid_d = req_valid;
    rsp_cost_d  = rsp_cost_q;
    rsp_avail_d = rsp_avail_q;
    if (req_valid) begin
      rsp_avail_d = req_in_range && (rd_data != '0);
      rsp_cost_d  = rsp_avail_d ? rd_data : '0;
    end

    wr_res_d = WR_IDLE;
    if (wr_en) begin
      wr_res_d = wr_accept ? WR_ACK : WR_ERR;
    end
  end

  // Response pipeline and write-result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_cost_q  <= '0;
      rsp_avail_q <= 1'b0;
      wr_res_q    <= WR_IDLE;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_cost_q  <= rsp_cost_d;
      rsp_avail_q <= rsp_avail_d;
      wr_res_q    <= wr_res_d;
    end
  end

  // Output decode; one encoded result keeps ack and err mutually exclusive
  always_comb begin
    rsp_valid = rsp_valid_q;
    rsp_cost  = rsp_cost_q;
    rsp_avail = rsp_avail_q;
    wr_ack    = (wr_res_q == WR_ACK);
    wr_err    = (wr_res_q == WR_ERR);
  end

endmodule

// File: doc/product_price_table.md
Name: product_price_table

Overview:
Parametrised, programmable successor to the fixed product cost lookup. Holds one price register per product slot, loaded with default prices at reset and rewritable at run time through a write port that can be locked. Price queries use a valid-pulse request and return a registered response one cycle later. It sits between the product-select/keypad logic and the coin-accumulation/change FSM.

Parameters:
NUM_PRODUCTS, 4, number of product slots (>=2)
PRICE_W, 8, price width in currency units
SEL_W, $clog2(NUM_PRODUCTS), selector width (derived; do not override)
DEFAULT_PRICES, {8'd0,8'd40,8'd20,8'd10}, packed NUM_PRODUCTS*PRICE_W reset prices; slot i = bits [i*PRICE_W +: PRICE_W]

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  price query strobe, one cycle per query
req_sel  in  SEL_W  product queried
rsp_valid  out  1  response strobe, exactly one cycle after req_valid
rsp_cost  out  PRICE_W  price of queried product (0 when not available)
rsp_avail  out  1  1 = slot in range and price nonzero
wr_en  in  1  price write strobe
wr_sel  in  SEL_W  slot to write
wr_price  in  PRICE_W  new price
lock  in  1  level; 1 = writes rejected
wr_ack  out  1  one-cycle pulse, write accepted
wr_err  out  1  one-cycle pulse, write rejected (locked or out of range)

Behaviour:
- One clock; reset is asynchronous and active-high. All state is in clk rising-edge flops with async clear/preset on rst.
- Reset: price[i] = DEFAULT_PRICES slot i; rsp_valid=0, rsp_cost=0, rsp_avail=0, wr_ack=0, wr_err=0.
- Reset mid-operation: an in-flight query is dropped (no rsp_valid) and pending writes are discarded; prices revert to defaults.
- Query: req_valid high at edge N, so rsp_valid=1 during cycle N+1 with rsp_cost/rsp_avail computed from the price table as it stood before edge N. Back-to-back queries are supported every cycle with no stall.
- When rsp_valid=0, rsp_cost and rsp_avail hold their last values; consumers sample only on rsp_valid.
- Out-of-range req_sel (>= NUM_PRODUCTS, possible only when not a power of two): rsp_cost=0, rsp_avail=0, rsp_valid still asserted.
- Price 0 means the slot is not for sale: rsp_avail=0, rsp_cost=0.
- Write: wr_en at edge N with lock=0 and wr_sel < NUM_PRODUCTS updates price[wr_sel]=wr_price at edge N, and wr_ack=1 during cycle N+1. Otherwise there is no update and wr_err=1 during cycle N+1. wr_ack and wr_err are never both 1.
- Writing a price of 0 is legal and disables the slot.
- Simultaneous query and write to the same slot in the same cycle: the response carries the OLD price (read-before-write). The next query sees the new price.
- lock is sampled on the same edge as wr_en. Toggling lock has no other effect.
- No arithmetic beyond the compare; prices are stored verbatim with no saturation or width conversion.

Decomposition:
- Shared package vm_pkg: PRICE_W default, default price constants (PRICE_P0=10, PRICE_P1=20, PRICE_P2=40), product-index typedef. These are shared with the coin/change FSM.
- One sub-module, price_regfile: NUM_PRODUCTS x PRICE_W registers with an async-reset-to-default value, one write port and one combinational read port. The top level adds the request/response pipeline, range and zero checks, and ack/err generation.

Test Plan:
1. Reset, then query sel 0,1,2,3 on consecutive cycles -> rsp_valid in each following cycle with cost 10,20,40,0 and avail 1,1,1,0.
2. lock=0, write sel 1 = 25 -> wr_ack pulses for one cycle; a query of sel 1 two cycles later returns 25, avail=1.
3. lock=1, write sel 2 = 99 -> wr_err pulses, no wr_ack; a query of sel 2 returns 40.
4. In the same cycle, write sel 0 = 15 and query sel 0 -> response returns 10; the next query returns 15.
5. NUM_PRODUCTS=3: query sel 3 -> rsp_valid=1, cost 0, avail 0. Write sel 3 -> wr_err.
6. Write sel 2 = 30, issue a query, assert rst in the same cycle the response would appear -> rsp_valid stays 0; after release, sel 2 reads 40.
